instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter HALT_ADDR, default 32'h00000000: fetch address that terminates execution.
REQ-002 Parameter TIMEOUT, default 16: maximum imem_waitrequest cycles tolerated per fetch.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset (reset==0 resets on the next posedge clk).
REQ-005 addr  input  32  current PC value from the program counter.
REQ-006 stall  input  1  downstream execute not ready; holds the current instruction.
REQ-007 imem_address  output  32  instruction memory word address; equals addr.
REQ-008 imem_read  output  1  instruction memory read request.
REQ-009 imem_waitrequest  input  1  memory not ready; the request must be held.
REQ-010 imem_readdata  input  32  instruction word returned by memory.
REQ-011 instr  output  32  registered instruction word.
REQ-012 instr_valid  output  1  instr holds a valid, unretired instruction.
REQ-013 state  output  1  one-cycle commit pulse; the PC advances when it is 1.
REQ-014 halt  output  1  execution stopped (sticky).
REQ-015 fault  output  1  memory timeout occurred (sticky).

Function
REQ-016 FSM states SHALL be IDLE, FETCH, EXEC, HALTED; the state register is the only sequential control besides the wait counter and instr.
REQ-017 IDLE SHALL transition to FETCH unconditionally one cycle after reset deasserts.
REQ-018 In FETCH: imem_read SHALL be 1 combinationally iff addr!=HALT_ADDR, and imem_address SHALL equal addr.
REQ-019 FETCH with addr==HALT_ADDR SHALL go to HALTED next cycle, with imem_read 0 and no memory access.
REQ-020 FETCH with imem_read=1 and imem_waitrequest=0 SHALL capture imem_readdata into instr at that edge and go to EXEC.
REQ-021 Fetch latency: minimum 1 cycle in FETCH, with instr_valid=1 on the following cycle.
REQ-022 In FETCH, the wait counter SHALL increment each cycle imem_waitrequest=1; the counter is cleared on every entry to FETCH.
REQ-023 If the wait counter reaches TIMEOUT while imem_waitrequest=1, the FSM SHALL go to HALTED with fault=1 and halt=1, and instr SHALL be unchanged.
REQ-024 In EXEC: instr_valid SHALL be 1; state SHALL be 1 combinationally iff stall=0, and the FSM then returns to FETCH.
REQ-025 In EXEC with stall=1: the FSM SHALL hold, with state=0 and instr and instr_valid unchanged, for any number of cycles.
REQ-026 state SHALL be 0 in IDLE, FETCH and HALTED, so the PC is never advanced outside a commit.
REQ-027 In FETCH after a commit, the new addr SHALL be used (PC updated at the commit edge).
REQ-028 HALTED SHALL be absorbing until reset, with halt=1, imem_read=0, state=0 and instr_valid=0.
REQ-029 instr_valid SHALL be 0 in IDLE, FETCH and HALTED.
REQ-030 stall SHALL be ignored in all states other than EXEC.
REQ-031 instr SHALL be passed through unmodified (no byte swapping).

Reset
REQ-032 On reset==0 at posedge clk, from any state, including mid-wait: FSM=IDLE, instr=0, instr_valid=0, state=0, halt=0, fault=0, imem_read=0, and wait counter=0.
REQ-033 A read in progress during reset SHALL be abandoned; imem_readdata arriving after reset SHALL be ignored until a new FETCH.

Structure
REQ-034 The FSM state enum and the HALT_ADDR default constant SHALL live in a shared package, cpu_pkg.
REQ-035 The block SHALL be a single module with no sub-modules; the wait counter width is $clog2(TIMEOUT+1).

Verification
REQ-036 Zero-wait fetch: reset released, addr=32'hBFC00000, waitrequest=0, readdata=32'h24020005 -> imem_read=1 for 1 cycle, next cycle instr=32'h24020005 and instr_valid=1, state=1 (stall=0).
REQ-037 Wait states: waitrequest=1 for 3 cycles then 0 -> imem_read held 4 cycles with constant imem_address, then a single commit pulse.
REQ-038 Stall: stall=1 for 5 cycles in EXEC -> state=0 and instr stable for 5 cycles; state=1 on the cycle stall drops.
REQ-039 Halt: after a commit, addr=32'h00000000 -> no imem_read, halt=1 next cycle and stays 1 for 20+ cycles, fault=0.
REQ-040 Timeout: waitrequest held at 1 -> after 16 wait cycles, fault=1, halt=1, imem_read=0, and instr retains its previous value.
REQ-041 Reset mid-wait: reset=0 during the 2nd wait cycle -> next cycle all outputs at reset values, and a fresh fetch begins after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states and the default halt address.
package cpu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] HALT_ADDR_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      EXEC   = 2'd2,
      HALTED = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one imem read per PC value, holds the word
// while execute stalls, and signals a one-cycle commit to advance the PC.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] HALT_ADDR = HALT_ADDR_DEFAULT,
   parameter int unsigned     TIMEOUT   = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] addr,
   input  logic            stall,
   output logic [XLEN-1:0] imem_address,
   output logic            imem_read,
   input  logic            imem_waitrequest,
   input  logic [XLEN-1:0] imem_readdata,
   output logic [XLEN-1:0] instr,
   output logic            instr_valid,
   output logic            state,
   output logic            halt,
   output logic            fault
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   fetch_state_t     fsm_q;
   fetch_state_t     fsm_d;
   logic [CNT_W-1:0] wait_cnt_q;
   logic [CNT_W-1:0] wait_cnt_d;
   logic             capture;

   // State register, wait counter and instruction latch.
   always_ff @(posedge clk) begin
      if (!reset) begin
         fsm_q      <= IDLE;
         wait_cnt_q <= '0;
         instr      <= '0;
      end else begin
         fsm_q      <= fsm_d;
         wait_cnt_q <= wait_cnt_d;
         if (capture) begin
            instr <= imem_readdata;
         end
      end
   end

   // Next state and combinational memory/commit handshakes.
   always_comb begin
      fsm_d      = fsm_q;
      wait_cnt_d = wait_cnt_q;
      imem_read  = 1'b0;
      state      = 1'b0;
      capture    = 1'b0;

      unique case (fsm_q)
         IDLE: begin
            fsm_d      = FETCH;
            wait_cnt_d = '0;
         end
         FETCH: begin
            if (addr == HALT_ADDR) begin
               fsm_d = HALTED;
            end else begin
               imem_read = 1'b1;
               if (!imem_waitrequest) begin
                  capture = 1'b1;
                  fsm_d   = EXEC;
               end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  // Counter parks at TIMEOUT so HALTED can tell a timeout from a halt.
                  wait_cnt_d = CNT_W'(TIMEOUT);
                  fsm_d      = HALTED;
               end else begin
                  wait_cnt_d = wait_cnt_q + CNT_W'(1);
               end
            end
         end
         EXEC: begin
            if (!stall) begin
               state      = 1'b1;
               fsm_d      = FETCH;
               wait_cnt_d = '0;
            end
         end
         HALTED: begin
            fsm_d = HALTED;
         end
         default: begin
            fsm_d = IDLE;
         end
      endcase
   end

   assign imem_address = addr;
   assign instr_valid  = (fsm_q == EXEC);
   assign halt         = (fsm_q == HALTED);
   assign fault        = halt && (wait_cnt_q == CNT_W'(TIMEOUT));

endmodule
